// File: rtl/mm_pkg.sv
// ============================================================================
// mm_pkg : shared word/line widths and types for the sequencer/collector pair
// Revision: 1.0
// ============================================================================
`default_nettype none

package mm_pkg;
  localparam int MM_DATA_WIDTH = 32;
  localparam int MM_LINE_WIDTH = 256;

  typedef logic [MM_DATA_WIDTH-1:0] mm_word_t;
  typedef logic [MM_LINE_WIDTH-1:0] mm_line_t;
endpackage

`default_nettype wire

// File: rtl/mm_sync_fifo.sv
// ============================================================================
// mm_sync_fifo : first-word-fall-through synchronous FIFO with full/empty/count
// Revision: 1.0
// ============================================================================
`default_nettype none

module mm_sync_fifo
  import mm_pkg::*;
#(
  parameter int  WIDTH = MM_LINE_WIDTH,
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNTW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  // A pop frees the head slot in the same cycle, so push into a full FIFO is legal then.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + CNTW'(do_push) - CNTW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

endmodule

`default_nettype wire

// File: rtl/data_collector.sv
// ============================================================================
// data_collector : packs narrow words LSB-first into wide lines, buffers them
//                  in an FWFT FIFO and flags dropped lines
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_collector
  import mm_pkg::*;
#(
  parameter int  DATA_INPUT_WIDTH  = MM_DATA_WIDTH,
  parameter int  DATA_OUTPUT_WIDTH = MM_LINE_WIDTH,
  parameter int  FIFO_DEPTH        = 2,
  localparam int WORDS             = DATA_OUTPUT_WIDTH / DATA_INPUT_WIDTH,
  localparam int CW                = $clog2(WORDS + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         valid_i,
  input  logic [DATA_INPUT_WIDTH-1:0]  data_i,
  input  logic                         flush_i,
  output logic [DATA_OUTPUT_WIDTH-1:0] data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [CW-1:0]                word_cnt_o,
  output logic                         overflow_o
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_OUTPUT_WIDTH-1:0] pack_q, pack_d, merged;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         overflow_q, overflow_d;
  logic                         push, pop, complete;
  logic                         fifo_full, fifo_empty;
  logic [FCW-1:0]               fifo_count;

  // The incoming word is merged before the push decision so a flush or
  // completion in the same cycle carries it.
  always_comb begin
    merged = pack_q;
    if (valid_i) merged[cnt_q*DATA_INPUT_WIDTH +: DATA_INPUT_WIDTH] = data_i;
    complete   = valid_i && (cnt_q == CW'(WORDS - 1));
    push       = complete || (flush_i && (valid_i || (cnt_q != '0)));
    pop        = ready_i && (fifo_count != '0);
    cnt_d      = push ? '0 : cnt_q + CW'(valid_i);
    pack_d     = push ? '0 : merged;
    overflow_d = overflow_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pack_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      pack_q     <= pack_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  mm_sync_fifo #(
    .WIDTH (DATA_OUTPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (merged),
    .pop_i   (pop),
    .data_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign valid_o    = ~fifo_empty;
  assign word_cnt_o = cnt_q;
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_data_collector.sv
// ============================================================================
// tb_data_collector : directed scenarios plus random traffic against a
//                     queue-based model of the collector
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_collector;
  localparam int IW    = 32;
  localparam int OW    = 256;
  localparam int WORDS = OW / IW;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(WORDS + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          valid_i = 1'b0;
  logic [IW-1:0] data_i = '0;
  logic          flush_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [OW-1:0] data_o;
  logic          valid_o;
  logic [CW-1:0] word_cnt_o;
  logic          overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: pending narrow words, buffered lines, sticky overflow
  logic [IW-1:0] m_part[$];
  logic [OW-1:0] m_fifo[$];
  bit            m_ovf = 1'b0;

  data_collector #(
    .DATA_INPUT_WIDTH  (IW),
    .DATA_OUTPUT_WIDTH (OW),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .flush_i    (flush_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .word_cnt_o (word_cnt_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, apply the model's rules at the edge, compare after the edge.
  task automatic step(input bit v, input logic [IW-1:0] d, input bit f, input bit r, input bit rn);
    logic [OW-1:0] line;
    bit            pop;
    valid_i = v;
    data_i  = d;
    flush_i = f;
    ready_i = r;
    reset_n = rn;
    @(posedge clk);
    if (!rn) begin
      m_part.delete();
      m_fifo.delete();
      m_ovf = 1'b0;
    end else begin
      pop = (m_fifo.size() > 0) && r;
      if (v) m_part.push_back(d);
      if (pop) void'(m_fifo.pop_front());
      if (m_part.size() == WORDS || (f && m_part.size() > 0)) begin
        line = '0;
        for (int k = 0; k < m_part.size(); k++) line[k*IW +: IW] = m_part[k];
        m_part.delete();
        if (m_fifo.size() < DEPTH) m_fifo.push_back(line);
        else m_ovf = 1'b1;
      end
    end
    #1;
    check_eq("valid_o", OW'(valid_o), OW'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) check_eq("data_o", data_o, m_fifo[0]);
    check_eq("word_cnt_o", OW'(word_cnt_o), OW'(m_part.size()));
    check_eq("overflow_o", OW'(overflow_o), OW'(m_ovf));
  endtask

  task automatic feed_line(input logic [IW-1:0] base, input bit r);
    for (int i = 0; i < WORDS; i++) step(1'b1, base + IW'(i), 1'b0, r, 1'b1);
  endtask

  initial begin
    logic [OW-1:0] exp_line;

    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_data_o", data_o, '0);
    check_eq("reset_valid_o", OW'(valid_o), '0);

    // 1: eight words back-to-back form one line
    feed_line(32'h1, 1'b1);
    exp_line = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
    check_eq("t1_line", data_o, exp_line);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check_eq("t1_single_valid", OW'(valid_o), '0);

    // 2: partial line closed by a lone flush
    step(1'b1, 32'hA, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'hB, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'hC, 1'b0, 1'b1, 1'b1);
    check_eq("t2_cnt3", OW'(word_cnt_o), OW'(3));
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    check_eq("t2_line", data_o, {160'h0, 32'hC, 32'hB, 32'hA});
    check_eq("t2_cnt0", OW'(word_cnt_o), '0);

    // 3: empty flush is a no-op; flush on the completing word pushes once
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    check_eq("t3_empty_flush", OW'(valid_o), '0);
    for (int i = 0; i < WORDS - 1; i++) step(1'b1, 32'h100 + IW'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h107, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check_eq("t3_one_push", OW'(valid_o), '0);

    // 4: three lines with the consumer stalled; the third is dropped
    feed_line(32'h1000, 1'b0);
    exp_line = data_o;
    feed_line(32'h2000, 1'b0);
    feed_line(32'h3000, 1'b0);
    check_eq("t4_overflow", OW'(overflow_o), OW'(1));
    check_eq("t4_head_stable", data_o, exp_line);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check_eq("t4_drained", OW'(valid_o), '0);

    // 5: full FIFO popped on the completion edge of the third line
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    feed_line(32'h4000, 1'b0);
    feed_line(32'h5000, 1'b0);
    for (int i = 0; i < WORDS - 1; i++) step(1'b1, 32'h6000 + IW'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h6007, 1'b0, 1'b1, 1'b1);
    check_eq("t5_no_overflow", OW'(overflow_o), '0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // 6: reset mid-line with a pending FIFO entry
    feed_line(32'h7000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'hDEAD0000 + IW'(i), 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("t6_rst_data", data_o, '0);
    check_eq("t6_rst_valid", OW'(valid_o), '0);
    check_eq("t6_rst_cnt", OW'(word_cnt_o), '0);
    feed_line(32'h8000, 1'b1);
    exp_line = '0;
    for (int k = 0; k < WORDS; k++) exp_line[k*IW +: IW] = 32'h8000 + IW'(k);
    check_eq("t6_clean_line", data_o, exp_line);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(99) < 75, $urandom, $urandom_range(99) < 8,
           $urandom_range(99) < 45, $urandom_range(299) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
